// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle between the terminal buffer and the UART transmitter.
interface uart_tx_if;
  logic [7:0] i_byte;
  logic       i_byte_v;
  logic       o_tx_serial;
  logic       o_tx_active;
  logic       o_tx_done;
  logic       o_full;
  logic       o_overflow;

  modport master (
    output i_byte, i_byte_v,
    input  o_tx_serial, o_tx_active, o_tx_done, o_full, o_overflow
  );
  modport slave (
    input  i_byte, i_byte_v,
    output o_tx_serial, o_tx_active, o_tx_done, o_full, o_overflow
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shift FSM.
// All outputs are registered; reset is asynchronous and active-low.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          pop, push;

  state_e        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          serial_q, active_q, done_q, full_q, ovf_q;

  // A full FIFO still takes a byte when the FSM pops in the same cycle.
  assign pop  = (state_q == IDLE) && (cnt_q != '0);
  assign push = bus.i_byte_v && ((cnt_q != DEPTH_N) || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + NW'(1);
    else if (pop && !push) cnt_d = cnt_q - NW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.i_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_N);
      ovf_q  <= bus.i_byte_v && !push;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          shift_q   <= mem_q[rd_q];
          clk_cnt_q <= '0;
          bit_q     <= '0;
          serial_q  <= 1'b0;
          active_q  <= 1'b1;
          state_q   <= START;
        end
        START: if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_q <= '0;
          serial_q  <= shift_q[0];
          state_q   <= DATA;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        DATA: if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_q <= '0;
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_q     <= bit_q + 3'd1;
          // Line is registered, so the next bit is taken from shift_q[1] before the shift lands.
          if (bit_q == 3'd7) begin
            serial_q <= 1'b1;
            state_q  <= STOP;
          end else serial_q <= shift_q[1];
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        STOP: if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_q <= '0;
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_tx_serial = serial_q;
  assign bus.o_tx_active = active_q;
  assign bus.o_tx_done   = done_q;
  assign bus.o_full      = full_q;
  assign bus.o_overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed and random stimulus for uart_tx, checked against a frame-timeline model and a line decoder.
module tb_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
  localparam int F = 10 * C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus();
  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_ovf  = 0;

  // Model: FIFO as a queue, frame on the line described by its start edge and byte.
  byte unsigned mq[$];
  byte unsigned sent[$];
  logic       m_have = 1'b0;
  int         m_s = 0;
  logic [7:0] m_b = '0;
  int         cyc = 0;
  logic       m_ovf = 1'b0, m_full = 1'b0, m_pop, m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_have = 1'b0;
      m_ovf  = 1'b0;
      m_full = 1'b0;
    end else begin
      cyc++;
      m_pop = (!m_have || cyc > m_s + F) && (mq.size() != 0);
      m_acc = bus.i_byte_v && (mq.size() < D || m_pop);
      if (m_pop) begin
        m_b = mq.pop_front();
        m_s = cyc;
        m_have = 1'b1;
        sent.push_back(m_b);
      end
      if (m_acc) mq.push_back(bus.i_byte);
      m_ovf  = bus.i_byte_v && !m_acc;
      m_full = (mq.size() == D);
    end
  end

  function automatic logic exp_active();
    return m_have && cyc >= m_s && cyc < m_s + F;
  endfunction
  function automatic logic exp_done();
    return m_have && cyc == m_s + F;
  endfunction
  function automatic logic exp_serial();
    int idx;
    if (!exp_active()) return 1'b1;
    idx = (cyc - m_s) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_b[idx-1];
    return 1'b1;
  endfunction

  // Independent line decoder, sampling mid-cycle at the centre of each bit.
  int rx[$];
  int rxc = -1;
  logic [7:0] rxs;
  always @(negedge clk) begin
    if (!rst) rxc = -1;
    else if (rxc < 0) begin
      if (!bus.o_tx_serial) rxc = 0;
    end else begin
      rxc++;
      if (rxc % C == C / 2 && rxc / C >= 1 && rxc / C <= 8) rxs[rxc / C - 1] = bus.o_tx_serial;
      if (rxc == 9 * C + C / 2) begin
        rx.push_back((bus.o_tx_serial ? 0 : 256) + int'(rxs));
        rxc = -1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    chk("serial", bus.o_tx_serial, exp_serial());
    chk("active", bus.o_tx_active, exp_active());
    chk("done",   bus.o_tx_done,   exp_done());
    chk("full",   bus.o_full,      m_full);
    chk("ovf",    bus.o_overflow,  m_ovf);
    if (bus.o_tx_done)  n_done++;
    if (bus.o_overflow) n_ovf++;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.i_byte = b; bus.i_byte_v = 1'b1;
    tick();
    bus.i_byte_v = 1'b0;
  endtask

  task automatic chk_rx(input string tag, input int exp[$]);
    chk({tag, "_n"}, rx.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx.size(); i++) chk(tag, rx[i], exp[i]);
  endtask

  logic seq41 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.i_byte = '0; bus.i_byte_v = 1'b0;
    repeat (3) tick();
    chk("rst_serial", bus.o_tx_serial, 1'b1);
    chk("rst_active", bus.o_tx_active, 1'b0);
    chk("rst_full",   bus.o_full,      1'b0);
    rst = 1'b1;
    repeat (3) tick();

    // Single byte, exact waveform
    rx.delete(); n_done = 0;
    wr(8'h41);
    for (int k = 0; k < F; k++) begin
      tick();
      chk("t1_line", bus.o_tx_serial, seq41[k / C]);
      chk("t1_act",  bus.o_tx_active, 1'b1);
    end
    tick();
    chk("t1_done", bus.o_tx_done, 1'b1);
    chk("t1_act_off", bus.o_tx_active, 1'b0);
    repeat (5) tick();
    chk("t1_ndone", n_done, 1);
    chk_rx("t1_rx", '{32'h41});

    // Back-to-back
    rx.delete(); n_done = 0; n_ovf = 0;
    wr(8'h55); wr(8'hAA); wr(8'h0F);
    repeat (3 * (F + 1) + 5) tick();
    chk("t2_ndone", n_done, 3);
    chk("t2_novf", n_ovf, 0);
    chk_rx("t2_rx", '{32'h55, 32'hAA, 32'h0F});

    // Overflow
    rx.delete(); n_ovf = 0;
    for (int i = 0; i < 6; i++) begin
      wr(8'(8'h30 + i));
      if (i == 4) chk("t3_full", bus.o_full, 1'b1);
      if (i == 5) chk("t3_ovf", bus.o_overflow, 1'b1);
    end
    repeat (5 * (F + 1) + 5) tick();
    chk("t3_novf", n_ovf, 1);
    chk_rx("t3_rx", '{32'h30, 32'h31, 32'h32, 32'h33, 32'h34});

    // Full FIFO, write on the done cycle
    rx.delete(); n_ovf = 0;
    for (int i = 0; i < 5; i++) wr(8'(8'hA0 + i));
    begin
      int n = 0;
      while (!bus.o_tx_done && n < 2 * F) begin tick(); n++; end
    end
    chk("t4_done_seen", bus.o_tx_done, 1'b1);
    chk("t4_full_at_done", bus.o_full, 1'b1);
    wr(8'h7E);
    chk("t4_no_ovf", bus.o_overflow, 1'b0);
    repeat (5 * (F + 1) + 5) tick();
    chk("t4_novf", n_ovf, 0);
    chk_rx("t4_rx", '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h7E});

    // Reset during data bit 3 with two bytes queued
    n_done = 0;
    wr(8'hB1); wr(8'hB2); wr(8'hB3);
    repeat (15) tick();
    #2 rst = 1'b0;
    #1;
    chk("t5_serial", bus.o_tx_serial, 1'b1);
    chk("t5_active", bus.o_tx_active, 1'b0);
    chk("t5_full",   bus.o_full,      1'b0);
    rx.delete();
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      chk("t5_idle", bus.o_tx_serial, 1'b1);
    end
    chk("t5_ndone", n_done, 0);
    chk("t5_rx", rx.size(), 0);

    // Held strobe
    rx.delete();
    bus.i_byte = 8'h0D; bus.i_byte_v = 1'b1;
    tick(); tick();
    bus.i_byte_v = 1'b0;
    repeat (2 * (F + 1) + 5) tick();
    chk_rx("t6_rx", '{32'h0D, 32'h0D});

    // Random traffic
    rx.delete(); sent.delete();
    for (int k = 0; k < 600; k++) begin
      bus.i_byte   = 8'($urandom);
      bus.i_byte_v = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.i_byte_v = 1'b0;
    repeat ((D + 1) * (F + 1) + 5) tick();
    begin
      int exp_q[$];
      foreach (sent[i]) exp_q.push_back(int'(sent[i]));
      chk_rx("rand_rx", exp_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter stage that sits directly downstream of the terminal buffer. It consumes the buffer's byte/valid output and shifts each byte onto the TX line as 8N1 UART frames. It returns the `i_tx_active` / `i_tx_done` status the buffer's refresh, cursor and tab sequencers wait on. A small FIFO absorbs bytes that arrive while a frame is in flight, so back-to-back escape sequences are not lost.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per bit. 217 is 25 MHz / 115200. Must be ≥ 2.
- `FIFO_DEPTH`, 4, byte FIFO entries. Must be a power of two, ≥ 2.
- `clk`  input  1  system clock; everything is on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `i_byte`  input  8  byte to send.
- `i_byte_v`  input  1  write strobe. Every cycle it is high is one byte.
- `o_tx_serial`  output  1  UART line. Idles high.
- `o_tx_active`  output  1  high while a frame (start through stop) is on the line.
- `o_tx_done`  output  1  one-cycle pulse after each frame's stop bit.
- `o_full`  output  1  FIFO holds `FIFO_DEPTH` entries.
- `o_overflow`  output  1  one-cycle pulse when a byte is dropped.

## Operation
- Reset (`rst`=0, asynchronous):
  - `o_tx_serial`=1; `o_tx_active`, `o_tx_done`, `o_full`, `o_overflow` all 0.
  - FIFO emptied; FSM forced to IDLE; counters cleared.
  - Takes effect immediately, including mid-frame. The line goes high with no done pulse.
- FIFO:
  - Read pointer, write pointer and a count. Count width is `$clog2(FIFO_DEPTH)+1`.
  - A write accepted with `i_byte_v`=1 when count < `FIFO_DEPTH`, or when count is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `o_overflow` pulses in the following cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line high. If FIFO non-empty, at the edge: pop the head into the shift register, clear counters, go to START.
  - START: line 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: line = shift[0], LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After each bit, shift right and increment a 3-bit bit counter. After bit 7, go to STOP.
  - STOP: line 1 for `CLKS_PER_BIT` cycles, then go to IDLE and assert `o_tx_done` for that first IDLE cycle.
- The clock counter has width `$clog2(CLKS_PER_BIT)`. It counts 0 to `CLKS_PER_BIT`-1, then resets to 0.
- `o_tx_active`=1 in START, DATA and STOP; 0 in IDLE, including the done cycle.
- The pop in IDLE may occur on the done cycle itself. The gap between frames is then exactly 1 idle-high cycle.

## Timing
- Idle and empty FIFO, write sampled at edge E0:
  - Pop at E1.
  - Start bit and `o_tx_active`=1 visible from E1.
  - Frame is 10×`CLKS_PER_BIT` cycles.
  - `o_tx_done`=1 for the single cycle from E1+10·`CLKS_PER_BIT`.
- `o_full` reflects count after the edge (registered).
- `o_overflow` is registered and lasts 1 cycle per dropped byte.
- `o_tx_done` and `o_tx_active` are never high in the same cycle.
- Release of `rst` is synchronised by the integrator. The block makes no transmission after release until a new write.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: write 0x41 at E0.
  - Line from E1 is 0,1,0,0,0,0,0,1,0,1, each level held 4 cycles.
  - `o_tx_active` high for 40 cycles.
  - `o_tx_done` pulses once at E41.
- Back-to-back: write 0x55, 0xAA, 0x0F on consecutive cycles.
  - Three correct frames, separated by exactly 1 high cycle each.
  - Three done pulses; `o_overflow` never asserted.
- Overflow, `FIFO_DEPTH`=4: write 0x30–0x35 on six consecutive cycles from idle.
  - `o_full` high after E4.
  - `o_overflow` pulses once, after E5.
  - Frames 0x30–0x34 are sent; 0x35 is never sent.
- Full plus simultaneous pop: keep the FIFO full during a frame, then write 0x7E on the done cycle (the cycle the pop occurs).
  - Write is accepted with no overflow.
  - 0x7E is transmitted last.
- Reset mid-frame: drop `rst` during DATA bit 3 with 2 bytes queued.
  - Line high and `o_tx_active`=0 within the same cycle; no done pulse.
  - After release, line stays high indefinitely until a new write.
- Held strobe: `i_byte_v` high 2 cycles with `i_byte`=0x0D → two identical 0x0D frames.
